// File: rtl/exception_status_unit_pkg.sv
// Shared definitions for the exception status unit and the control decoder.
package exception_status_unit_pkg;

  // Exception codes carried in exception[1:0]; the upper bits are ignored.
  typedef enum logic [1:0] {
    ExcNone = 2'd0,
    ExcAdd  = 2'd1,
    ExcAddi = 2'd2,
    ExcSub  = 2'd3
  } exc_code_e;

  // Architectural register that mirrors rstatus.
  localparam logic [4:0] RegRstatus = 5'b11110;

  // One queued event: {code, pc}.
  localparam int unsigned EvtWidth = 34;

  function automatic logic is_exc_event(logic retire_valid, logic [31:0] exception);
    return retire_valid && (exc_code_e'(exception[1:0]) != ExcNone);
  endfunction

endpackage

// File: rtl/exception_status_unit_if.sv
// Retire-side inputs, status outputs and event-queue handshake of the status unit.
interface exception_status_unit_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            retire_valid;
  logic [31:0]     exception;
  logic [31:0]     retire_pc;
  logic            setx_valid;
  logic [26:0]     setx_target;
  logic            status_clear;
  logic [31:0]     rstatus;
  logic            bex_taken;
  logic            evt_valid;
  logic [1:0]      evt_code;
  logic [31:0]     evt_pc;
  logic            evt_ready;
  logic            evt_dropped;
  logic [CntW-1:0] evt_count;

  // Pipeline / handler side.
  modport master (
    output retire_valid, exception, retire_pc, setx_valid, setx_target, status_clear,
    output evt_ready,
    input  rstatus, bex_taken, evt_valid, evt_code, evt_pc, evt_dropped, evt_count
  );

  // Status unit side.
  modport slave (
    input  retire_valid, exception, retire_pc, setx_valid, setx_target, status_clear,
    input  evt_ready,
    output rstatus, bex_taken, evt_valid, evt_code, evt_pc, evt_dropped, evt_count
  );

endinterface

// File: rtl/exc_event_fifo.sv
// Exception event FIFO. Occupancy counter drives full/empty; pointers wrap modulo DEPTH.
// A push on a full queue is accepted only if a pop frees a slot in the same cycle.
module exc_event_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [CntW-1:0]  count_o
);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [DEPTH];

  logic full, empty, do_push, do_pop;

  // Pointer/counter next state and handshake qualification.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop_i && !empty;
    do_push  = push_i && (!full || do_pop);
    drop_o   = push_i && !do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (do_pop && !do_push) count_d = count_q - CntW'(1);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only visible when the queue is non-empty.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Head is forced to zero when the queue is empty.
  always_comb begin
    empty_o = empty;
    count_o = count_q;
    data_o  = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/exception_status_unit.sv
// Exception status unit: maintains rstatus (r30), the bex condition and a queue of
// exception events for the handler, with a sticky overflow flag.
module exception_status_unit
  import exception_status_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                     clock,
  input logic                     reset,
  exception_status_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]         rstatus_q, rstatus_d;
  logic                evt_dropped_q, evt_dropped_d;
  logic                exc_event, setx_event, pop;
  logic                fifo_empty, fifo_drop;
  logic [EvtWidth-1:0] push_data, head_data;
  logic [CntW-1:0]     fifo_count;
  logic                unused_exc_hi;

  assign unused_exc_hi = ^bus.exception[31:2];

  // Event decode and rstatus priority: exception > setx > clear.
  always_comb begin
    exc_event  = is_exc_event(bus.retire_valid, bus.exception);
    setx_event = bus.retire_valid && bus.setx_valid;
    pop        = !fifo_empty && bus.evt_ready;
    push_data  = {bus.exception[1:0], bus.retire_pc};
    rstatus_d  = rstatus_q;
    if (exc_event)             rstatus_d = {30'b0, bus.exception[1:0]};
    else if (setx_event)       rstatus_d = {5'b0, bus.setx_target};
    else if (bus.status_clear) rstatus_d = '0;
  end

  // Sticky drop flag; software may clear it only once the queue has drained.
  always_comb begin
    evt_dropped_d = evt_dropped_q;
    if (fifo_drop)                           evt_dropped_d = 1'b1;
    else if (bus.status_clear && fifo_empty) evt_dropped_d = 1'b0;
  end

  // Status registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rstatus_q     <= '0;
      evt_dropped_q <= 1'b0;
    end else begin
      rstatus_q     <= rstatus_d;
      evt_dropped_q <= evt_dropped_d;
    end
  end

  exc_event_fifo #(
    .Width (EvtWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (exc_event),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  // Output mapping; bex_taken is a pure decode of the registered status.
  always_comb begin
    bus.rstatus     = rstatus_q;
    bus.bex_taken   = (rstatus_q != '0);
    bus.evt_valid   = !fifo_empty;
    bus.evt_code    = head_data[33:32];
    bus.evt_pc      = head_data[31:0];
    bus.evt_dropped = evt_dropped_q;
    bus.evt_count   = fifo_count;
  end

endmodule

// File: tb/tb_exception_status_unit.sv
// Directed bench for exception_status_unit with a queue-based reference model.
module tb_exception_status_unit;

  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exception_status_unit_if #(.DEPTH(DEPTH)) bus ();

  exception_status_unit #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [33:0] m_q[$];
  logic [31:0] m_rstatus = '0;
  logic        m_dropped = 1'b0;

  // Model: apply the rules to the inputs seen at each rising edge.
  always @(posedge clock) begin
    logic exc, was_empty;
    if (!reset) begin
      m_q.delete();
      m_rstatus = '0;
      m_dropped = 1'b0;
    end else begin
      exc       = bus.retire_valid && (bus.exception[1:0] != 2'd0);
      was_empty = (m_q.size() == 0);
      if (!was_empty && bus.evt_ready) void'(m_q.pop_front());
      if (exc) begin
        if (m_q.size() < DEPTH) m_q.push_back({bus.exception[1:0], bus.retire_pc});
        else m_dropped = 1'b1;
      end
      if (!(exc && m_dropped && m_q.size() == DEPTH) && bus.status_clear && was_empty)
        m_dropped = 1'b0;
      if (exc) m_rstatus = {30'b0, bus.exception[1:0]};
      else if (bus.retire_valid && bus.setx_valid) m_rstatus = {5'b0, bus.setx_target};
      else if (bus.status_clear) m_rstatus = '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once reset has taken effect.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_rstatus", bus.rstatus, m_rstatus);
      chk("m_bex", 32'(bus.bex_taken), 32'(m_rstatus != 0));
      chk("m_valid", 32'(bus.evt_valid), 32'(m_q.size() != 0));
      chk("m_code", 32'(bus.evt_code), (m_q.size() != 0) ? 32'(m_q[0][33:32]) : 32'd0);
      chk("m_pc", bus.evt_pc, (m_q.size() != 0) ? m_q[0][31:0] : 32'd0);
      chk("m_count", 32'(bus.evt_count), 32'(m_q.size()));
      chk("m_dropped", 32'(bus.evt_dropped), 32'(m_dropped));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    bus.retire_valid = 1'b0;
    bus.exception    = '0;
    bus.retire_pc    = '0;
    bus.setx_valid   = 1'b0;
    bus.setx_target  = '0;
    bus.status_clear = 1'b0;
    bus.evt_ready    = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [31:0] pc, input logic rdy);
    bus.retire_valid = 1'b1;
    bus.exception    = {30'b0, c};
    bus.retire_pc    = pc;
    bus.evt_ready    = rdy;
    cyc();
  endtask

  task automatic pop_expect(input logic [31:0] pc);
    chk("pop_order", bus.evt_pc, pc);
    bus.evt_ready = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.retire_valid = 1'b0;
    bus.exception    = '0;
    bus.retire_pc    = '0;
    bus.setx_valid   = 1'b0;
    bus.setx_target  = '0;
    bus.status_clear = 1'b0;
    bus.evt_ready    = 1'b0;
    reset = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b1;
    chk("rst_rstatus", bus.rstatus, 32'd0);
    chk("rst_count", 32'(bus.evt_count), 32'd0);
    chk("rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_dropped", 32'(bus.evt_dropped), 32'd0);

    // Add overflow at 0x40.
    push(2'd1, 32'h40, 1'b0);
    chk("add_rstatus", bus.rstatus, 32'd1);
    chk("add_bex", 32'(bus.bex_taken), 32'd1);
    chk("add_valid", 32'(bus.evt_valid), 32'd1);
    chk("add_code", 32'(bus.evt_code), 32'd1);
    chk("add_pc", bus.evt_pc, 32'h40);
    cyc();  // held: ready low
    chk("hold_pc", bus.evt_pc, 32'h40);
    pop_expect(32'h40);
    chk("empty_code", 32'(bus.evt_code), 32'd0);
    chk("empty_pc", bus.evt_pc, 32'd0);

    // setx alone, setx with ignored upper exception bits, setx vs exception.
    bus.retire_valid = 1'b1; bus.setx_valid = 1'b1; bus.setx_target = 27'h123;
    cyc();
    chk("setx_rstatus", bus.rstatus, 32'h123);
    chk("setx_count", 32'(bus.evt_count), 32'd0);
    bus.retire_valid = 1'b1; bus.setx_valid = 1'b1; bus.setx_target = 27'h5;
    bus.exception = 32'hABCD_0000;
    cyc();
    chk("hi_bits_rstatus", bus.rstatus, 32'h5);
    chk("hi_bits_count", 32'(bus.evt_count), 32'd0);
    bus.setx_valid = 1'b1; bus.setx_target = 27'h7FF_FFFF;
    push(2'd3, 32'h80, 1'b0);
    chk("setx_vs_exc", bus.rstatus, 32'd3);
    chk("setx_vs_exc_code", 32'(bus.evt_code), 32'd3);
    pop_expect(32'h80);

    // status_clear loses to exception, then works alone.
    bus.status_clear = 1'b1;
    push(2'd2, 32'h90, 1'b0);
    chk("clr_vs_exc", bus.rstatus, 32'd2);
    bus.status_clear = 1'b1;
    cyc();
    chk("clr_rstatus", bus.rstatus, 32'd0);
    chk("clr_bex", 32'(bus.bex_taken), 32'd0);
    pop_expect(32'h90);

    // Overflow: five pushes into a depth-4 queue.
    for (int i = 0; i < 5; i++) push(2'(i % 3 + 1), 32'h100 + 32'(i), 1'b0);
    chk("ovf_count", 32'(bus.evt_count), 32'd4);
    chk("ovf_dropped", 32'(bus.evt_dropped), 32'd1);
    bus.status_clear = 1'b1;
    cyc();
    chk("sticky_nonempty", 32'(bus.evt_dropped), 32'd1);
    for (int i = 0; i < 4; i++) pop_expect(32'h100 + 32'(i));
    bus.status_clear = 1'b1;
    cyc();
    chk("clr_dropped", 32'(bus.evt_dropped), 32'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) push(2'd1, 32'h300 + 32'(i), 1'b0);
    push(2'd3, 32'h200, 1'b1);
    chk("full_pp_count", 32'(bus.evt_count), 32'd4);
    chk("full_pp_dropped", 32'(bus.evt_dropped), 32'd0);
    chk("full_pp_head", bus.evt_pc, 32'h301);
    pop_expect(32'h301);
    pop_expect(32'h302);
    pop_expect(32'h303);
    pop_expect(32'h200);

    // Mid-operation reset overrides same-cycle inputs.
    push(2'd1, 32'h400, 1'b0);
    push(2'd3, 32'h404, 1'b0);
    push(2'd2, 32'h408, 1'b0);
    chk("pre_rst_rstatus", bus.rstatus, 32'd2);
    chk("pre_rst_count", 32'(bus.evt_count), 32'd3);
    reset = 1'b0;
    push(2'd1, 32'h500, 1'b1);
    chk("mid_rst_count", 32'(bus.evt_count), 32'd0);
    chk("mid_rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("mid_rst_rstatus", bus.rstatus, 32'd0);
    chk("mid_rst_dropped", 32'(bus.evt_dropped), 32'd0);
    push(2'd2, 32'h504, 1'b1);
    chk("in_rst_count", 32'(bus.evt_count), 32'd0);
    reset = 1'b1;
    push(2'd2, 32'h600, 1'b0);
    chk("post_rst_pc", bus.evt_pc, 32'h600);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
